timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped countdown timer that acts as the responder behind the system bridge's timer windows. It decodes the word address and write strobe the bridge already forwards, holds three 32-bit registers (CTRL, PRESET, COUNT), and runs a four-state countdown FSM. It raises a maskable interrupt toward the CPU. Two instances serve the TC0 and TC1 windows; each returns read data on `dout` for the bridge's read mux.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  30 (`[31:2]`)  word address from the bridge; only `addr[3:2]` is decoded.
- `wen`  in  1  write strobe from the bridge; high means a write to the register selected by `addr[3:2]`.
- `din`  in  32  write data.
- `dout`  out  32  combinational read data for the register selected by `addr[3:2]`.
- `irq`  out  1  interrupt request, equal to `irq_flag & CTRL.IM`.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0 = CTRL, read/write. `[0]` EN, `[2:1]` MODE, `[3]` IM. Bits `[31:4]` are ignored on write and read as 0.
  - 1 = PRESET, read/write, 32 bits.
  - 2 = COUNT, read-only; writes are ignored.
  - 3 = unused; reads return 0 and writes are ignored.
- MODE values: `00` = one-shot, `01` = auto-reload. `1x` is treated as one-shot.
- FSM states and transitions:
  - IDLE: if CTRL.EN = 1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET, then go to CNT.
  - CNT:
    - If EN = 0, go to IDLE; COUNT holds its value.
    - Else if COUNT > 1, COUNT <= COUNT - 1.
    - Else (COUNT ≤ 1, including PRESET = 0), COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, one-shot mode: CTRL.EN <= 0, go to IDLE. irq_flag stays set.
  - INT, auto-reload mode: irq_flag <= 0, go to LOAD. This gives a one-cycle irq pulse.
- irq_flag is cleared by any write to CTRL.
- Arithmetic: COUNT is unsigned 32-bit and never decrements below 0. There is no wrap-around.
- The FSM always reads the registered CTRL value, never `din`.

## Timing
- Reset values (asynchronous, while `reset` = 0):
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - state = IDLE, irq_flag = 0.
  - `irq` = 0; `dout` reads 0 at every address.
- Writes commit on the rising edge where `wen` = 1. Readback through `dout` is visible in the same cycle after that edge.
- One-shot latency: CTRL is written with EN = 1 at edge E0.
  - LOAD is entered at E1.
  - COUNT = PRESET at E2.
  - INT is entered and `irq` rises (if IM = 1) at edge E(PRESET+2), with PRESET ≥ 1.
  - PRESET = 0 behaves like PRESET = 1: INT at E3.
- Auto-reload period is PRESET + 2 cycles between INT entries. Each INT gives `irq` high for exactly one cycle.
- Simultaneous events:
  - A CTRL write in the same cycle as the INT-state clear of EN: the software write wins, so CTRL takes `din[3:0]`. irq_flag is cleared.
  - A CTRL write in the same cycle as CNT→INT: the write wins for CTRL, and irq_flag is still set, because the FSM set has priority over the write-clear.
  - A PRESET write during CNT does not change COUNT. It takes effect at the next LOAD.
  - Writing EN = 0 during CNT: IDLE at the next edge, COUNT frozen, `irq` unchanged.
- Reset asserted mid-count: everything returns to reset values immediately, independent of `clk`.

## Test plan
- Reset: hold `reset` = 0, toggle `clk` → CTRL/PRESET/COUNT read 0 and `irq` = 0. Release → still 0, state IDLE.
- One-shot: write PRESET = 3, then CTRL = `0x9` (EN = 1, MODE = 00, IM = 1) at E0 → COUNT reads 3, 2, 1, 0 after E2..E5. `irq` = 1 from E5 and stays high; CTRL reads `0x8` after E6. Writing CTRL = 0 drops `irq`.
- Auto-reload: PRESET = 2, CTRL = `0xB` → `irq` is a one-cycle pulse every 4 cycles. COUNT sequence is 2, 1, 0, 0(LOAD), 2, …
- Mask: PRESET = 1, CTRL = `0x1` (IM = 0) → no `irq` at any point. COUNT reaches 0 and EN self-clears.
- Pause/edge: PRESET = 0 → INT at E3. Separately, PRESET = 10, clear EN mid-count at COUNT = 6 → COUNT holds at 6 and no `irq`. A PRESET write during CNT leaves COUNT unchanged.
- Decode: read addr[3:2] = 3 returns 0; a write to COUNT (addr[3:2] = 2) is ignored. Asserting `reset` mid-count with COUNT = 5 → all registers 0 immediately.

Source files
------------

// File: rtl/timer_counter_if.sv
// Register-bus connection between the system bridge and one timer window.
// The bridge drives the address, strobe and write data; the timer returns read data and irq.
interface timer_counter_if;
  logic [31:2] addr;
  logic        wen;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, wen, din, input  dout, irq);
  modport slave  (input  addr, wen, din, output dout, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation, and a maskable interrupt.
module timer_counter (
   input  logic           clk,
   input  logic           reset,
   timer_counter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_irq_flag;

   logic [1:0]  w_sel;
   logic        w_wr_ctrl;
   logic        w_wr_preset;
   logic        w_en;
   logic        w_auto_reload;
   logic [31:0] w_count_nxt;
   logic        w_flag_set;
   logic        w_flag_clr;
   logic        w_en_clr;
   logic [31:0] w_dout;
   logic        w_unused_addr;

   assign w_sel         = bus.addr[3:2];
   assign w_wr_ctrl     = bus.wen && (w_sel == A_CTRL);
   assign w_wr_preset   = bus.wen && (w_sel == A_PRESET);
   assign w_en          = r_ctrl[0];
   // MODE 1x falls back to one-shot, so only the exact 01 encoding reloads.
   assign w_auto_reload = (r_ctrl[2:1] == 2'b01);
   assign w_unused_addr = ^bus.addr[31:4];

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_flag_set  = 1'b0;
      w_flag_clr  = 1'b0;
      w_en_clr    = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_en) w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = S_CNT;
         end
         S_CNT: begin
            if (!w_en) begin
               w_state_nxt = S_IDLE;
            end else if (r_count > 32'd1) begin
               w_count_nxt = r_count - 32'd1;
            end else begin
               w_count_nxt = '0;
               w_flag_set  = 1'b1;
               w_state_nxt = S_INT;
            end
         end
         S_INT: begin
            if (w_auto_reload) begin
               w_flag_clr  = 1'b1;
               w_state_nxt = S_LOAD;
            end else begin
               w_en_clr    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_irq_flag <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         // The FSM's set beats a simultaneous software clear.
         if (w_flag_set)                    r_irq_flag <= 1'b1;
         else if (w_flag_clr || w_wr_ctrl)  r_irq_flag <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl   <= '0;
         r_preset <= '0;
      end else begin
         if (w_wr_ctrl)     r_ctrl    <= bus.din[3:0];
         else if (w_en_clr) r_ctrl[0] <= 1'b0;
         if (w_wr_preset)   r_preset  <= bus.din;
      end
   end

   always_comb begin
      w_dout = '0;
      unique case (w_sel)
         A_CTRL:   w_dout = {28'd0, r_ctrl};
         A_PRESET: w_dout = r_preset;
         A_COUNT:  w_dout = r_count;
         default:  w_dout = '0;
      endcase
   end

   assign bus.dout = w_dout;
   assign bus.irq  = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: randomized presets checked against
// closed-form expectations for count value and irq timing per clock edge.
module tb_timer_counter;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   timer_counter_if bus ();

   timer_counter u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic [1:0] idx, input logic [31:0] d, input logic we);
      bus.addr = {28'($urandom()), idx};
      bus.din  = d;
      bus.wen  = we;
   endtask

   task automatic bus_write(input logic [1:0] idx, input logic [31:0] d);
      set_bus(idx, d, 1'b1);
      tick();
      bus.wen = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
      set_bus(idx, $urandom(), 1'b0);
      #1;
      d = bus.dout;
   endtask

   task automatic do_reset();
      bus.wen = 1'b0;
      reset   = 1'b0;
      #2;
      reset   = 1'b1;
   endtask

   // Expected count after edge k of a single countdown that loaded at E2.
   function automatic logic [31:0] model_count(input int p, input int k);
      int v;
      if (k < 2) return 32'd0;
      v = p - (k - 2);
      return (v < 0) ? 32'd0 : 32'(v);
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      set_bus(2'd0, 32'hF, 1'b1);
      repeat (3) tick();
      bus.wen = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hold_read a=%0d: got %0h expected 0", a, d);
         end
      end
      n_checks++;
      if (bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold_irq: got %b expected 0", bus.irq);
      end
      reset = 1'b1;
      repeat (3) tick();
      for (int a = 0; a < 3; a++) begin
         bus_read(2'(a), d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release_read a=%0d: got %0h expected 0", a, d);
         end
      end
   endtask

   task automatic test_oneshot(input int p);
      logic [31:0] d;
      int t, int_edge;
      do_reset();
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, 32'h9);
      t = (p == 0) ? 1 : p;
      int_edge = t + 2;
      for (int k = 1; k <= int_edge + 2; k++) begin
         tick();
         bus_read(2'd2, d);
         n_checks++;
         if (d !== model_count(p, k)) begin
            n_fail++;
            $display("FAIL oneshot_count p=%0d k=%0d: got %0d expected %0d", p, k, d, model_count(p, k));
         end
         n_checks++;
         if (bus.irq !== (k >= int_edge)) begin
            n_fail++;
            $display("FAIL oneshot_irq p=%0d k=%0d: got %b expected %b", p, k, bus.irq, k >= int_edge);
         end
      end
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h8) begin
         n_fail++;
         $display("FAIL oneshot_en_clear p=%0d: got %0h expected 8", p, d);
      end
      bus_write(2'd0, 32'h0);
      n_checks++;
      if (bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_irq_clear p=%0d: got %b expected 0", p, bus.irq);
      end
   endtask

   task automatic test_autoreload(input int p);
      logic [31:0] d, exp_c;
      logic exp_irq;
      int t, per, m, pulses, exp_pulses;
      do_reset();
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, 32'hB);
      t = (p == 0) ? 1 : p;
      per = t + 2;
      pulses = 0;
      exp_pulses = 0;
      for (int k = 1; k <= 3 * per + 3; k++) begin
         tick();
         exp_irq = (k >= per) && ((k - per) % per == 0);
         if (k < 2) begin
            exp_c = 32'd0;
         end else begin
            m = (k - 2) % per;
            exp_c = (m <= t) ? model_count(p, m + 2) : 32'd0;
         end
         if (exp_irq) exp_pulses++;
         if (bus.irq === 1'b1) pulses++;
         bus_read(2'd2, d);
         n_checks++;
         if (d !== exp_c) begin
            n_fail++;
            $display("FAIL auto_count p=%0d k=%0d: got %0d expected %0d", p, k, d, exp_c);
         end
         n_checks++;
         if (bus.irq !== exp_irq) begin
            n_fail++;
            $display("FAIL auto_irq p=%0d k=%0d: got %b expected %b", p, k, bus.irq, exp_irq);
         end
      end
      n_checks++;
      if (pulses != exp_pulses) begin
         n_fail++;
         $display("FAIL auto_pulse_count p=%0d: got %0d expected %0d", p, pulses, exp_pulses);
      end
   endtask

   task automatic test_mask(input int p);
      logic [31:0] d;
      int t;
      do_reset();
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, 32'h1);
      t = (p == 0) ? 1 : p;
      for (int k = 1; k <= t + 5; k++) begin
         tick();
         n_checks++;
         if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_irq p=%0d k=%0d: got %b expected 0", p, k, bus.irq);
         end
      end
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL mask_count p=%0d: got %0d expected 0", p, d);
      end
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL mask_en_clear p=%0d: got %0h expected 0", p, d);
      end
   endtask

   // EN is cleared by a write that commits on edge stop_k; COUNT must freeze at that edge's value.
   task automatic test_pause(input int p, input int stop_k);
      logic [31:0] d, exp_c;
      do_reset();
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, 32'h9);
      for (int k = 1; k <= stop_k + 5; k++) begin
         if (k == stop_k) set_bus(2'd0, 32'h8, 1'b1);
         tick();
         bus.wen = 1'b0;
         exp_c = model_count(p, (k <= stop_k) ? k : stop_k);
         bus_read(2'd2, d);
         n_checks++;
         if (d !== exp_c) begin
            n_fail++;
            $display("FAIL pause_count p=%0d stop=%0d k=%0d: got %0d expected %0d", p, stop_k, k, d, exp_c);
         end
         n_checks++;
         if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_irq k=%0d: got %b expected 0", k, bus.irq);
         end
      end
   endtask

   task automatic test_preset_during_cnt();
      logic [31:0] d, np;
      np = 32'd100 + 32'($urandom_range(0, 50));
      do_reset();
      bus_write(2'd1, 32'd8);
      bus_write(2'd0, 32'h9);
      for (int k = 1; k <= 9; k++) begin
         if (k == 4) set_bus(2'd1, np, 1'b1);
         tick();
         bus.wen = 1'b0;
         bus_read(2'd2, d);
         n_checks++;
         if (d !== model_count(8, k)) begin
            n_fail++;
            $display("FAIL preset_cnt_count k=%0d: got %0d expected %0d", k, d, model_count(8, k));
         end
      end
      repeat (3) tick();
      bus_read(2'd1, d);
      n_checks++;
      if (d !== np) begin
         n_fail++;
         $display("FAIL preset_readback: got %0d expected %0d", d, np);
      end
      bus_write(2'd0, 32'h9);
      tick();
      tick();
      bus_read(2'd2, d);
      n_checks++;
      if (d !== np) begin
         n_fail++;
         $display("FAIL preset_next_load: got %0d expected %0d", d, np);
      end
   endtask

   // wr_k_off 0: CTRL write on the CNT->INT edge; 1: on the INT edge that clears EN.
   task automatic test_simul(input int p, input int wr_k_off, input logic [31:0] wdata);
      logic [31:0] d, exp_ctrl;
      logic exp_irq;
      int int_edge;
      do_reset();
      bus_write(2'd1, 32'(p));
      bus_write(2'd0, 32'h9);
      int_edge = p + 2;
      for (int k = 1; k <= int_edge + wr_k_off; k++) begin
         if (k == int_edge + wr_k_off) set_bus(2'd0, wdata, 1'b1);
         tick();
         bus.wen = 1'b0;
      end
      exp_ctrl = {28'd0, wdata[3:0]};
      exp_irq  = (wr_k_off == 0) ? wdata[3] : 1'b0;
      bus_read(2'd0, d);
      n_checks++;
      if (d !== exp_ctrl) begin
         n_fail++;
         $display("FAIL simul_ctrl off=%0d: got %0h expected %0h", wr_k_off, d, exp_ctrl);
      end
      n_checks++;
      if (bus.irq !== exp_irq) begin
         n_fail++;
         $display("FAIL simul_irq off=%0d: got %b expected %b", wr_k_off, bus.irq, exp_irq);
      end
      if (wr_k_off == 0) begin
         tick();
         bus_read(2'd0, d);
         n_checks++;
         if (d !== (exp_ctrl & 32'hE)) begin
            n_fail++;
            $display("FAIL simul_ctrl_after_int: got %0h expected %0h", d, exp_ctrl & 32'hE);
         end
      end
   endtask

   task automatic test_decode();
      logic [31:0] d, pv;
      pv = $urandom();
      do_reset();
      bus_write(2'd0, 32'hFFFF_FFF6);
      bus_write(2'd1, pv);
      bus_write(2'd2, 32'h1234_5678);
      bus_write(2'd3, 32'hDEAD_BEEF);
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h6) begin
         n_fail++;
         $display("FAIL decode_ctrl_mask: got %0h expected 6", d);
      end
      bus_read(2'd1, d);
      n_checks++;
      if (d !== pv) begin
         n_fail++;
         $display("FAIL decode_preset: got %0h expected %0h", d, pv);
      end
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL decode_count_ro: got %0h expected 0", d);
      end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL decode_unused: got %0h expected 0", d);
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      do_reset();
      bus_write(2'd1, 32'd10);
      bus_write(2'd0, 32'h9);
      for (int k = 1; k <= 7; k++) tick();
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd5) begin
         n_fail++;
         $display("FAIL midreset_precount: got %0d expected 5", d);
      end
      reset = 1'b0;
      #1;
      for (int a = 0; a < 3; a++) begin
         bus_read(2'(a), d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_read a=%0d: got %0h expected 0", a, d);
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      bus.addr = '0;
      bus.wen  = 1'b0;
      bus.din  = '0;
      reset    = 1'b0;
      test_reset();
      test_oneshot(3);
      test_oneshot(0);
      repeat (4) test_oneshot(int'($urandom_range(1, 12)));
      test_autoreload(2);
      test_autoreload(0);
      repeat (3) test_autoreload(int'($urandom_range(1, 6)));
      test_mask(1);
      test_mask(int'($urandom_range(0, 8)));
      test_pause(10, 6);
      test_pause(int'($urandom_range(12, 20)), int'($urandom_range(3, 9)));
      test_preset_during_cnt();
      test_simul(int'($urandom_range(1, 6)), 0, 32'h9);
      test_simul(int'($urandom_range(1, 6)), 1, 32'hD);
      test_decode();
      test_reset_midcount();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
